snoop_cache_ctrl: RTL and testbench

//  Per-core coherence controller; the core-side end of the shared snooping bus. Owns a direct-mapped
//  MSI tag/state store, raises read/write miss requests toward the bus arbiter, waits for its grant,
//  and answers snoop searches the arbiter broadcasts on behalf of the other core. One instance per cpu.

---
 rtl/snoop_cache_ctrl.sv | 164 ++++++++++++++++
 tb/tb_snoop_cache_ctrl.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/snoop_cache_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | snoop_cache_ctrl : per-core MSI controller on the shared snooping bus.   |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module snoop_cache_ctrl #(
  parameter int ADDR_W = 16,
  parameter int IDX_W  = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_re,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  output logic              cpu_stall,
  output logic              read_miss,
  output logic              write_miss,
  output logic              write_miss_state,
  output logic [ADDR_W-1:0] miss_addr,
  output logic              victim_dirty,
  input  logic              cpu_datasel,
  input  logic [ADDR_W-1:0] tag_in,
  input  logic              cpu_search,
  input  logic              snoop_inv,
  output logic              cpu_search_found,
  output logic              supply_data
);

  localparam int TAG_W = ADDR_W - IDX_W;
  localparam int LINES = 1 << IDX_W;

  localparam logic [1:0] ST_I = 2'b00;
  localparam logic [1:0] ST_S = 2'b01;
  localparam logic [1:0] ST_M = 2'b10;

  localparam logic [1:0] FSM_IDLE = 2'd0;
  localparam logic [1:0] FSM_REQ  = 2'd1;
  localparam logic [1:0] FSM_FILL = 2'd2;

  logic [TAG_W-1:0]  tag_q [LINES];
  logic [1:0]        st_q  [LINES];
  logic [1:0]        fsm_q, fsm_d;
  logic              rd_q, rd_d, wr_q, wr_d, wms_q, wms_d, vic_q, vic_d;
  logic              fillm_q, fillm_d, found_q, found_d, supply_q, supply_d;
  logic [ADDR_W-1:0] maddr_q, maddr_d;

  logic [IDX_W-1:0] w_cidx, w_sidx, w_midx;
  logic [1:0]       w_cst, w_sst;
  logic             w_ctag_eq, w_chit, w_shit, w_access, w_cmiss, w_core_go;

  // Core-side and snoop-side lookups run in parallel against the same store.
  assign w_cidx    = cpu_addr[IDX_W-1:0];
  assign w_cst     = st_q[w_cidx];
  assign w_ctag_eq = tag_q[w_cidx] == cpu_addr[ADDR_W-1:IDX_W];
  assign w_chit    = w_ctag_eq && (w_cst == ST_S || w_cst == ST_M);
  assign w_access  = cpu_re | cpu_we;
  assign w_cmiss   = cpu_re ? !w_chit : (cpu_we && !(w_chit && w_cst == ST_M));
  assign w_core_go = !cpu_search && w_access && w_cmiss;

  assign w_sidx = tag_in[IDX_W-1:0];
  assign w_sst  = st_q[w_sidx];
  assign w_shit = (tag_q[w_sidx] == tag_in[ADDR_W-1:IDX_W]) && (w_sst == ST_S || w_sst == ST_M);
  assign w_midx = maddr_q[IDX_W-1:0];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fsm_q    <= FSM_IDLE;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
      wms_q    <= 1'b0;
      vic_q    <= 1'b0;
      fillm_q  <= 1'b0;
      found_q  <= 1'b0;
      supply_q <= 1'b0;
      maddr_q  <= '0;
      for (int i = 0; i < LINES; i++) begin
        st_q[i]  <= ST_I;
        tag_q[i] <= '0;
      end
    end else begin
      fsm_q    <= fsm_d;
      rd_q     <= rd_d;
      wr_q     <= wr_d;
      wms_q    <= wms_d;
      vic_q    <= vic_d;
      fillm_q  <= fillm_d;
      found_q  <= found_d;
      supply_q <= supply_d;
      maddr_q  <= maddr_d;
      if (cpu_search && w_shit)
        st_q[w_sidx] <= snoop_inv ? ST_I : ST_S;
      // Fill is written last so it wins over a same-cycle snoop on that line.
      if (fsm_q == FSM_FILL) begin
        tag_q[w_midx] <= maddr_q[ADDR_W-1:IDX_W];
        st_q[w_midx]  <= fillm_q ? ST_M : ST_S;
      end
    end
  end

  always_comb begin
    fsm_d = fsm_q;
    case (fsm_q)
      FSM_IDLE: if (w_core_go) fsm_d = FSM_REQ;
      FSM_REQ:  if (cpu_datasel) fsm_d = FSM_FILL;
      FSM_FILL: fsm_d = FSM_IDLE;
      default:  fsm_d = FSM_IDLE;
    endcase
  end

  always_comb begin
    rd_d     = rd_q;
    wr_d     = wr_q;
    wms_d    = wms_q;
    vic_d    = vic_q;
    fillm_d  = fillm_q;
    maddr_d  = maddr_q;
    found_d  = cpu_search && w_shit;
    supply_d = cpu_search && w_shit && (w_sst == ST_M);
    case (fsm_q)
      FSM_IDLE: begin
        if (w_core_go) begin
          rd_d    = cpu_re;
          wr_d    = !cpu_re;
          wms_d   = !cpu_re && w_chit && (w_cst == ST_S);
          vic_d   = !w_ctag_eq && (w_cst == ST_M);
          fillm_d = !cpu_re;
          maddr_d = cpu_addr;
        end
      end
      FSM_REQ: begin
        // Losing the shared copy turns a pending upgrade into a full write miss.
        if (cpu_search && snoop_inv && w_shit && tag_in == maddr_q)
          wms_d = 1'b0;
        if (cpu_datasel) begin
          rd_d  = 1'b0;
          wr_d  = 1'b0;
          wms_d = 1'b0;
          vic_d = 1'b0;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    cpu_stall = 1'b0;
    case (fsm_q)
      FSM_IDLE: cpu_stall = w_access && (cpu_search || w_cmiss);
      FSM_REQ:  cpu_stall = 1'b1;
      FSM_FILL: cpu_stall = 1'b1;
      default:  cpu_stall = 1'b0;
    endcase
  end

  assign read_miss        = rd_q;
  assign write_miss       = wr_q;
  assign write_miss_state = wms_q;
  assign miss_addr        = maddr_q;
  assign victim_dirty     = vic_q;
  assign cpu_search_found = found_q;
  assign supply_data      = supply_q;

endmodule
`default_nettype wire

// File: tb/tb_snoop_cache_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_snoop_cache_ctrl : directed self-checking bench for snoop_cache_ctrl. |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module tb_snoop_cache_ctrl;

  logic        clk = 1'b0;
  logic        rst_n, cpu_re, cpu_we, cpu_datasel, cpu_search, snoop_inv;
  logic [15:0] cpu_addr, tag_in, miss_addr;
  logic        cpu_stall, read_miss, write_miss, write_miss_state, victim_dirty;
  logic        cpu_search_found, supply_data;
  int          n_cmp = 0;
  int          n_err = 0;

  snoop_cache_ctrl #(.ADDR_W(16), .IDX_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .cpu_re(cpu_re), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_stall(cpu_stall), .read_miss(read_miss), .write_miss(write_miss),
    .write_miss_state(write_miss_state), .miss_addr(miss_addr), .victim_dirty(victim_dirty),
    .cpu_datasel(cpu_datasel), .tag_in(tag_in), .cpu_search(cpu_search), .snoop_inv(snoop_inv),
    .cpu_search_found(cpu_search_found), .supply_data(supply_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".stall"}, 32'(cpu_stall), 0);
    chk({tag, ".rd"}, 32'(read_miss), 0);
    chk({tag, ".wr"}, 32'(write_miss), 0);
    chk({tag, ".wms"}, 32'(write_miss_state), 0);
    chk({tag, ".addr"}, 32'(miss_addr), 0);
    chk({tag, ".vic"}, 32'(victim_dirty), 0);
    chk({tag, ".found"}, 32'(cpu_search_found), 0);
    chk({tag, ".supply"}, 32'(supply_data), 0);
  endtask

  // Grant the pending miss; FILL cycle keeps stall high.
  task automatic grant(input string tag);
    cpu_datasel = 1'b1;
    tick();
    cpu_datasel = 1'b0;
    #1;
    chk({tag, ".fill_stall"}, 32'(cpu_stall), 1);
    chk({tag, ".fill_rd"}, 32'(read_miss), 0);
    chk({tag, ".fill_wr"}, 32'(write_miss), 0);
    tick();
  endtask

  initial begin
    rst_n = 1'b0; cpu_re = 1'b0; cpu_we = 1'b0; cpu_addr = '0;
    cpu_datasel = 1'b0; tag_in = '0; cpu_search = 1'b0; snoop_inv = 1'b0;
    tick(); tick();
    chk_all_zero("reset");
    rst_n = 1'b1;
    tick();

    // Read miss, grant, then line S serves reads without stall
    cpu_re = 1'b1; cpu_addr = 16'h0010; #1;
    chk("t1.detect_stall", 32'(cpu_stall), 1);
    tick();
    chk("t1.read_miss", 32'(read_miss), 1);
    chk("t1.write_miss", 32'(write_miss), 0);
    chk("t1.miss_addr", 32'(miss_addr), 32'h0010);
    chk("t1.victim", 32'(victim_dirty), 0);
    tick();
    chk("t1.hold_rd", 32'(read_miss), 1);
    chk("t1.hold_stall", 32'(cpu_stall), 1);
    grant("t1");
    chk("t1.done_stall", 32'(cpu_stall), 0);
    tick();
    chk("t1.hit_stall", 32'(cpu_stall), 0);
    chk("t1.hit_rd", 32'(read_miss), 0);

    // Upgrade of an S line
    cpu_re = 1'b0; cpu_we = 1'b1; #1;
    chk("t2.detect_stall", 32'(cpu_stall), 1);
    tick();
    chk("t2.write_miss", 32'(write_miss), 1);
    chk("t2.wms", 32'(write_miss_state), 1);
    chk("t2.read_miss", 32'(read_miss), 0);
    grant("t2");
    chk("t2.rewrite_stall", 32'(cpu_stall), 0);
    tick();
    chk("t2.rewrite_wr", 32'(write_miss), 0);

    // Conflicting read with dirty victim
    cpu_we = 1'b0; cpu_re = 1'b1; cpu_addr = 16'h0018; #1;
    chk("t4.detect_stall", 32'(cpu_stall), 1);
    tick();
    chk("t4.read_miss", 32'(read_miss), 1);
    chk("t4.victim", 32'(victim_dirty), 1);
    chk("t4.miss_addr", 32'(miss_addr), 32'h0018);
    tick();
    chk("t4.victim_held", 32'(victim_dirty), 1);
    grant("t4");
    chk("t4.vic_clear", 32'(victim_dirty), 0);

    // Full write miss over a clean victim
    cpu_re = 1'b0; cpu_we = 1'b1; cpu_addr = 16'h0010;
    tick();
    chk("wm.write_miss", 32'(write_miss), 1);
    chk("wm.wms", 32'(write_miss_state), 0);
    chk("wm.victim", 32'(victim_dirty), 0);
    grant("wm");
    chk("wm.hit_stall", 32'(cpu_stall), 0);
    cpu_we = 1'b0;

    // Snoops, back-to-back every cycle
    cpu_search = 1'b1; tag_in = 16'h0010; snoop_inv = 1'b0;
    tick();
    chk("t3.rd_found", 32'(cpu_search_found), 1);
    chk("t3.rd_supply", 32'(supply_data), 1);
    tick();
    chk("t3.s_found", 32'(cpu_search_found), 1);
    chk("t3.s_supply", 32'(supply_data), 0);
    snoop_inv = 1'b1;
    tick();
    chk("t3.inv_found", 32'(cpu_search_found), 1);
    chk("t3.inv_supply", 32'(supply_data), 0);
    snoop_inv = 1'b0; tag_in = 16'h0018;
    tick();
    chk("t3.other_found", 32'(cpu_search_found), 0);
    tag_in = 16'h0010;
    tick();
    chk("t3.after_inv_found", 32'(cpu_search_found), 0);
    cpu_search = 1'b0;
    tick();
    chk("t3.idle_found", 32'(cpu_search_found), 0);

    // Upgrade pending, then invalidated by snoop
    cpu_re = 1'b1; cpu_addr = 16'h0010;
    tick();
    chk("t5.read_miss", 32'(read_miss), 1);
    grant("t5r");
    cpu_re = 1'b0; cpu_we = 1'b1;
    tick();
    chk("t5.wms_up", 32'(write_miss_state), 1);
    cpu_search = 1'b1; tag_in = 16'h0010; snoop_inv = 1'b1;
    tick();
    cpu_search = 1'b0; snoop_inv = 1'b0;
    #1;
    chk("t5.inv_found", 32'(cpu_search_found), 1);
    chk("t5.wms_drop", 32'(write_miss_state), 0);
    chk("t5.wr_held", 32'(write_miss), 1);
    grant("t5w");
    chk("t5.m_stall", 32'(cpu_stall), 0);
    cpu_we = 1'b0;
    cpu_search = 1'b1;
    tick();
    cpu_search = 1'b0;
    #1;
    chk("t5.m_supply", 32'(supply_data), 1);

    // Snoop and core read collide; line now S
    cpu_re = 1'b1; cpu_addr = 16'h0010; cpu_search = 1'b1; tag_in = 16'h0010; #1;
    chk("t6.collide_stall", 32'(cpu_stall), 1);
    tick();
    cpu_search = 1'b0;
    #1;
    chk("t6.found", 32'(cpu_search_found), 1);
    chk("t6.supply", 32'(supply_data), 0);
    chk("t6.retry_stall", 32'(cpu_stall), 0);
    chk("t6.no_miss", 32'(read_miss), 0);

    // Reset while a miss is pending
    cpu_addr = 16'h0020;
    tick();
    chk("t6.req_rd", 32'(read_miss), 1);
    cpu_re = 1'b0; rst_n = 1'b0;
    tick();
    chk_all_zero("t6.rst");
    rst_n = 1'b1;
    cpu_search = 1'b1; tag_in = 16'h0010;
    tick();
    cpu_search = 1'b0;
    #1;
    chk("t6.lines_inv", 32'(cpu_search_found), 0);
    cpu_re = 1'b1; cpu_addr = 16'h0010; #1;
    chk("t6.read_misses", 32'(cpu_stall), 1);
    cpu_re = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
